// File: rtl/fifo_axis_framer.sv
// Adapts a standard-mode (one-cycle read latency) sync FIFO to an AXI-Stream master,
// cutting the stream into FRAME_LEN-beat frames marked with tlast.
module fifo_axis_framer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned FRAME_LEN = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  output logic [WIDTH-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic [15:0]      frame_cnt
);

  localparam logic [15:0] LastBeat = 16'(FRAME_LEN - 1);

  logic [WIDTH-1:0] buf_q [2];
  logic             head_q, tail_q;
  logic [1:0]       occ_q, occ_d;
  logic             inflight_q;
  logic             started_q;
  logic [15:0]      beat_q, beat_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             pop;
  logic [2:0]       level;

  always_comb begin
    m_axis_tvalid = (occ_q != 2'd0);
    m_axis_tdata  = buf_q[head_q];
    m_axis_tlast  = m_axis_tvalid && (beat_q == LastBeat);
    frame_cnt     = frame_cnt_q;
    pop           = m_axis_tvalid && m_axis_tready;
    // Entries held or on their way once this cycle's pop is accounted for.
    level         = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    fifo_rd_en    = started_q && !fifo_empty && (level < 3'd2);
    occ_d         = level[1:0];
    beat_d        = beat_q;
    if (pop) begin
      beat_d = (beat_q == LastBeat) ? 16'd0 : beat_q + 16'd1;
    end
    frame_cnt_d = frame_cnt_q;
    if (pop && m_axis_tlast) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        buf_q[i] <= '0;
      end
      head_q      <= 1'b0;
      tail_q      <= 1'b0;
      occ_q       <= 2'd0;
      inflight_q  <= 1'b0;
      started_q   <= 1'b0;
      beat_q      <= 16'd0;
      frame_cnt_q <= 16'd0;
    end else begin
      started_q   <= 1'b1;
      inflight_q  <= fifo_rd_en;
      occ_q       <= occ_d;
      beat_q      <= beat_d;
      frame_cnt_q <= frame_cnt_d;
      if (inflight_q) begin
        buf_q[tail_q] <= fifo_dout;
        tail_q        <= ~tail_q;
      end
      if (pop) begin
        head_q <= ~head_q;
      end
    end
  end

endmodule

// File: doc/fifo_axis_framer.md
FIFO_AXIS_FRAMER -- requirements
Module: fifo_axis_framer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width in bits.
REQ-002 The block SHALL have parameter FRAME_LEN, default 16, giving beats per frame; legal range 2..65535.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic rises on its positive edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port fifo_dout, input, WIDTH, read data from an upstream standard-mode (non-FWFT) sync FIFO.
REQ-006 The block SHALL have port fifo_empty, input, 1, the upstream FIFO empty flag.
REQ-007 The block SHALL have port fifo_rd_en, output, 1, the read strobe to the upstream FIFO.
REQ-008 The block SHALL have port m_axis_tdata, output, WIDTH, the AXI-Stream data.
REQ-009 The block SHALL have port m_axis_tvalid, output, 1, the AXI-Stream valid.
REQ-010 The block SHALL have port m_axis_tready, input, 1, the AXI-Stream ready from downstream.
REQ-011 The block SHALL have port m_axis_tlast, output, 1, marking the last beat of each frame.
REQ-012 The block SHALL have port frame_cnt, output, 16, the count of completed frames.

Function
REQ-013 Upstream read latency SHALL be treated as one cycle: fifo_rd_en high in cycle N means fifo_dout is captured in cycle N+1.
REQ-014 fifo_rd_en SHALL never assert while fifo_empty is high.
REQ-015 The block SHALL hold a 2-entry output buffer and track occ (0..2) and inflight (0..1).
REQ-016 fifo_rd_en SHALL assert iff !fifo_empty && (occ + inflight - pop) < 2, where pop = m_axis_tvalid && m_axis_tready.
REQ-017 The buffer SHALL never overflow; captured data SHALL never be dropped, duplicated or reordered.
REQ-018 m_axis_tvalid SHALL equal (occ != 0), and m_axis_tdata SHALL be the buffer head.
REQ-019 Once m_axis_tvalid is high, tvalid, tdata and tlast SHALL stay stable until a handshake occurs.
REQ-020 With the FIFO continuously non-empty and tready held high, the block SHALL sustain 1 beat/cycle with no bubbles after the first beat.
REQ-021 A simultaneous capture and pop in one cycle SHALL leave occ unchanged.
REQ-022 A 16-bit beat counter SHALL advance on each pop and wrap to 0 after the pop at FRAME_LEN-1.
REQ-023 m_axis_tlast SHALL be high iff m_axis_tvalid && beat counter == FRAME_LEN-1.
REQ-024 frame_cnt SHALL increment by 1 on each handshake with tlast high, wrapping from 65535 to 0.
REQ-025 If tready is low, the block SHALL stop reading once occ + inflight == 2, and resume in the cycle tready returns while data is pending.
REQ-026 If the FIFO runs empty mid-frame, tvalid SHALL drop, the beat counter SHALL hold, and the frame SHALL continue when data resumes.

Reset
REQ-027 While rst_n is low, fifo_rd_en, m_axis_tvalid, m_axis_tlast, m_axis_tdata, frame_cnt, occ, inflight and the beat counter SHALL all be 0.
REQ-028 Reset asserted mid-frame SHALL discard buffered and in-flight data.
REQ-029 After reset release, the first pop SHALL be beat 0 of a new frame.
REQ-030 fifo_rd_en SHALL stay low during reset and in the cycle of release.

Verification
REQ-031 Scenario (streaming): 32 bytes 0x01..0x20 preloaded, tready=1, FRAME_LEN=16 -> 32 consecutive beats 0x01..0x20; tlast on 0x10 and 0x20; frame_cnt = 2.
REQ-032 Scenario (backpressure): tready toggles 1/0 each cycle over 16 bytes -> all 16 bytes delivered in order; tdata stable while stalled; fifo_rd_en never seen with occ + inflight == 2.
REQ-033 Scenario (empty gap): 5 bytes written, 10-cycle gap, then 11 bytes -> one frame of 16 beats with tlast only on beat 16; no read while empty.
REQ-034 Scenario (reset mid-frame): rst_n pulsed low after beat 7 -> outputs 0 immediately; after restart, 16 new beats with tlast on the 16th; frame_cnt = 1.
REQ-035 Scenario (counter wrap): frame_cnt forced or run to 65535, then one more frame -> frame_cnt = 0.
REQ-036 Scenario (simultaneous capture/pop): occ = 1 with tready=1 and FIFO non-empty -> occ remains 1 every cycle; throughput 1 beat/cycle.
